floating_point_alu: RTL and testbench
=====================================

Name: floating_point_alu

Overview:
- Registered IEEE-754 binary64 arithmetic unit: add, subtract, multiply, divide and square root, selected by a 3-bit mode.
- Each operation class has its own dedicated, holding result register:
  - add/sub → result_add_sub
  - mul → result_mul
  - div/sqrt → result_div
- Used as a scalar FP execution slice inside a datapath; no handshake, one new operation accepted per cycle.

Parameters:
- None. Width is fixed at 64 bits (1 sign, 11 exponent, 52 fraction; bias 1023).

Ports:
- Clock           input   1   system clock, all state updates on rising edge
- Reset           input   1   synchronous, active-high reset
- fpalu_mode      input   3   operation select: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101-111 no-op
- operand_a       input   64  binary64 operand A (sqrt uses A only)
- operand_b       input   64  binary64 operand B (ignored for sqrt)
- result_add_sub  output  64  registered result of last add/sub
- result_mul      output  64  registered result of last mul
- result_div      output  64  registered result of last div or sqrt

Behaviour:
- Reset (sampled at rising Clock while Reset=1): all three result registers are set to 64'h0. Reset has priority over any operation.
- Latency:
  - Inputs are sampled at rising edge N; the result is visible after edge N.
  - Fixed latency of 1 cycle; throughput of 1 operation per cycle; combinational datapath.
- Output register updates:
  - Only the register belonging to the selected mode updates; the other two hold their values.
  - Modes 101-111 update no register.
- Operations:
  - add: A+B.
  - sub: A+(−B), implemented by flipping B's sign.
  - mul: A×B. Sign = sA^sB; exponent = eA+eB−1023; 53×53 significand product, normalised.
  - div: A/B. Sign = sA^sB; exponent = eA−eB+1023; 53-bit significand quotient with at least 2 extra bits, normalised.
  - sqrt: √A. Exponent made even before halving; bit-serial (restoring) integer square root of the significand.
- Add/sub alignment: align the smaller-exponent significand by right shift, keeping guard/round/sticky bits. Shift of 56 or more → only sticky survives. Add or subtract magnitudes, then normalise with a leading-zero count.
- Rounding: round-to-nearest-even on all operations, using guard/round/sticky. Mantissa overflow from rounding increments the exponent.
- Subnormal inputs are flushed to signed zero. A result with biased exponent ≤ 0 becomes signed zero; no subnormal outputs.
- Overflow (biased exponent ≥ 2047) → signed infinity.
- Special cases (canonical NaN = 64'h7FF8000000000000):
  - Any NaN input → canonical NaN.
  - Add/sub:
    - Inf−Inf with effective opposite signs → NaN; Inf ± finite → that Inf.
    - Exact zero result → +0, except (−0)+(−0) = −0.
  - Mul:
    - 0×Inf → NaN; Inf×finite → signed Inf.
    - 0×finite → signed zero.
  - Div:
    - 0/0 and Inf/Inf → NaN.
    - x/0 (x finite, nonzero) → signed Inf.
    - 0/x → signed zero.
    - x/Inf → signed zero; Inf/x → signed Inf.
  - Sqrt:
    - Negative nonzero A → NaN.
    - √(±0) = ±0; √(+Inf) = +Inf.
- Mode or operand changes between edges have no effect until the next rising edge.

Test Plan:
- Reset, then add: Reset=1 for 1 cycle → all outputs 0. Then A=0x4034800000000000 (20.5), B=0x4016000000000000 (5.5), mode 000 → result_add_sub=0x403A000000000000 (26.0); result_mul and result_div stay 0.
- Sub then mul: A=0x4041000000000000 (34), B=0x4000000000000000 (2), mode 001 → result_add_sub=0x4040000000000000 (32). Next cycle A=0xC054200000000000 (−80.5), B=0x4016000000000000 (5.5), mode 010 → result_mul=0xC07BAC0000000000 (−442.75); result_add_sub holds 0x4040000000000000.
- Divide: A=0x4059000000000000 (100), B=0xC020000000000000 (−8), mode 011 → result_div=0xC029000000000000 (−12.5). Then B=0 with A=0x4054200000000000 → result_div=0x7FF0000000000000 (+Inf).
- Square root: A=0x4054400000000000 (81), mode 100 → result_div=0x4022000000000000 (9). A=0xC000000000000000 (−2) → 0x7FF8000000000000.
- Rounding: A=0x4041000000000000 (34), B=0x400199999999999A (2.2), mode 001 → result_add_sub=0x403FCCCCCCCCCCCD (RNE).
- No-op and specials: mode 111 with any operands → no output changes. Mul 0×Inf (0x0, 0x7FF0000000000000) → result_mul=0x7FF8000000000000. Reset asserted together with a valid op → outputs 0.

Source files
------------

// File: rtl/floating_point_alu.sv
// Registered binary64 add/sub/mul/div/sqrt slice. Each operation class owns a holding
// result register; only the register of the selected mode is written on each edge.
module floating_point_alu (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  fpalu_mode,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    output logic [63:0] result_add_sub,
    output logic [63:0] result_mul,
    output logic [63:0] result_div
);

    localparam logic [63:0] CANON_NAN = 64'h7FF8000000000000;
    localparam logic [2:0]  MODE_ADD  = 3'b000;
    localparam logic [2:0]  MODE_SUB  = 3'b001;
    localparam logic [2:0]  MODE_MUL  = 3'b010;
    localparam logic [2:0]  MODE_DIV  = 3'b011;
    localparam logic [2:0]  MODE_SQRT = 3'b100;

    logic [63:0] result_add_sub_d, result_add_sub_q;
    logic [63:0] result_mul_d, result_mul_q;
    logic [63:0] result_div_d, result_div_q;

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    endfunction

    // Exponent field zero covers both true zeros and flushed subnormals.
    function automatic logic is_zero(input logic [63:0] x);
        return x[62:52] == 11'd0;
    endfunction

    function automatic logic [63:0] pack_inf(input logic s);
        return {s, 11'h7FF, 52'd0};
    endfunction

    function automatic logic [63:0] pack_zero(input logic s);
        return {s, 63'd0};
    endfunction

    // m holds the normalised significand (hidden bit at m[55]) followed by guard, round, sticky.
    function automatic logic [63:0] round_pack(input logic s, input logic signed [12:0] e,
                                               input logic [55:0] m);
        logic              up;
        logic              carry;
        logic [51:0]       frac;
        logic signed [12:0] e_r;
        logic [63:0]       res;
        up           = m[2] & (m[1] | m[0] | m[3]);
        {carry, frac} = {1'b0, m[54:3]} + {52'd0, up};
        e_r          = carry ? e + 13'sd1 : e;
        if (e_r >= 13'sd2047)
            res = pack_inf(s);
        else if (e_r <= 13'sd0)
            res = pack_zero(s);
        else
            res = {s, e_r[10:0], frac};
        return res;
    endfunction

    function automatic logic [5:0] lead_zeros(input logic [55:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 55; i >= 0; i--) begin
            if (v[i])
                found = 1'b1;
            else if (!found)
                n = n + 6'd1;
        end
        return n;
    endfunction

    // Restoring integer square root: returns {55-bit root, remainder-nonzero flag}.
    function automatic logic [55:0] isqrt(input logic [109:0] rad);
        logic [57:0] rem;
        logic [57:0] trial;
        logic [54:0] root;
        rem  = 58'd0;
        root = 55'd0;
        for (int i = 54; i >= 0; i--) begin
            rem   = {rem[55:0], rad[2*i+1 -: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[53:0], 1'b1};
            end else begin
                root = {root[53:0], 1'b0};
            end
        end
        return {root, |rem};
    endfunction

    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic              a_big;
        logic              s_big, s_sml;
        logic [10:0]       e_big, e_sml, diff;
        logic [55:0]       m_big, m_sml, aligned, mask, m_norm;
        logic [56:0]       sum;
        logic [5:0]        lz;
        logic [63:0]       res;
        a_big   = a[62:0] >= b[62:0];
        s_big   = a_big ? a[63] : b[63];
        s_sml   = a_big ? b[63] : a[63];
        e_big   = a_big ? a[62:52] : b[62:52];
        e_sml   = a_big ? b[62:52] : a[62:52];
        m_big   = {1'b1, (a_big ? a[51:0] : b[51:0]), 3'b000};
        m_sml   = {1'b1, (a_big ? b[51:0] : a[51:0]), 3'b000};
        diff    = e_big - e_sml;
        mask    = ~({56{1'b1}} << diff);
        aligned = (diff >= 11'd56) ? 56'd1
                                   : ((m_sml >> diff) | {55'd0, |(m_sml & mask)});
        sum     = (s_big == s_sml) ? ({1'b0, m_big} + {1'b0, aligned})
                                   : ({1'b0, m_big} - {1'b0, aligned});
        lz      = lead_zeros(sum[55:0]);
        m_norm  = sum[55:0] << lz;
        if (is_nan(a) || is_nan(b))
            res = CANON_NAN;
        else if (is_inf(a) && is_inf(b))
            res = (a[63] == b[63]) ? a : CANON_NAN;
        else if (is_inf(a))
            res = a;
        else if (is_inf(b))
            res = b;
        else if (is_zero(a) && is_zero(b))
            res = pack_zero(a[63] & b[63]);
        else if (is_zero(a))
            res = b;
        else if (is_zero(b))
            res = a;
        else if (sum == 57'd0)
            res = 64'd0;
        else if (sum[56])
            res = round_pack(s_big, $signed({2'b00, e_big}) + 13'sd1, {sum[56:2], sum[1] | sum[0]});
        else
            res = round_pack(s_big, $signed({2'b00, e_big}) - $signed({7'd0, lz}), m_norm);
        return res;
    endfunction

    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic               s;
        logic [105:0]       p;
        logic signed [12:0] e;
        logic [63:0]        res;
        s = a[63] ^ b[63];
        p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
        e = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
        if (is_nan(a) || is_nan(b))
            res = CANON_NAN;
        else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
            res = CANON_NAN;
        else if (is_inf(a) || is_inf(b))
            res = pack_inf(s);
        else if (is_zero(a) || is_zero(b))
            res = pack_zero(s);
        else if (p[105])
            res = round_pack(s, e + 13'sd1, {p[105:51], |p[50:0]});
        else
            res = round_pack(s, e, {p[104:50], |p[49:0]});
        return res;
    endfunction

    // Quotient carries 56 fractional bits of (sigA/sigB) so guard/round survive either normalisation.
    function automatic logic [63:0] fp_div(input logic [63:0] a, input logic [63:0] b);
        logic               s;
        logic [108:0]       num, den;
        logic [56:0]        q;
        logic [52:0]        r;
        logic signed [12:0] e;
        logic [63:0]        res;
        s   = a[63] ^ b[63];
        num = {1'b1, a[51:0], 56'd0};
        den = {56'd0, 1'b1, b[51:0]};
        q   = 57'(num / den);
        r   = 53'(num % den);
        e   = $signed({2'b00, a[62:52]}) - $signed({2'b00, b[62:52]}) + 13'sd1023;
        if (is_nan(a) || is_nan(b))
            res = CANON_NAN;
        else if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b)))
            res = CANON_NAN;
        else if (is_inf(a))
            res = pack_inf(s);
        else if (is_inf(b))
            res = pack_zero(s);
        else if (is_zero(b))
            res = pack_inf(s);
        else if (is_zero(a))
            res = pack_zero(s);
        else if (q[56])
            res = round_pack(s, e, {q[56:2], (|q[1:0]) | (|r)});
        else
            res = round_pack(s, e - 13'sd1, {q[55:1], q[0] | (|r)});
        return res;
    endfunction

    function automatic logic [63:0] fp_sqrt(input logic [63:0] a);
        logic signed [12:0] e_unb;
        logic [53:0]        sig;
        logic [55:0]        root;
        logic [63:0]        res;
        e_unb = $signed({2'b00, a[62:52]}) - 13'sd1023;
        // An odd exponent is folded into the significand so the halved exponent is exact.
        sig   = e_unb[0] ? {1'b1, a[51:0], 1'b0} : {1'b0, 1'b1, a[51:0]};
        root  = isqrt({sig, 56'd0});
        if (is_nan(a))
            res = CANON_NAN;
        else if (is_zero(a))
            res = pack_zero(a[63]);
        else if (a[63])
            res = CANON_NAN;
        else if (is_inf(a))
            res = pack_inf(1'b0);
        else
            res = round_pack(1'b0, (e_unb >>> 1) + 13'sd1023, root);
        return res;
    endfunction

    always_comb begin
        result_add_sub_d = result_add_sub_q;
        result_mul_d     = result_mul_q;
        result_div_d     = result_div_q;
        case (fpalu_mode)
            MODE_ADD:  result_add_sub_d = fp_add(operand_a, operand_b);
            MODE_SUB:  result_add_sub_d = fp_add(operand_a, {~operand_b[63], operand_b[62:0]});
            MODE_MUL:  result_mul_d     = fp_mul(operand_a, operand_b);
            MODE_DIV:  result_div_d     = fp_div(operand_a, operand_b);
            MODE_SQRT: result_div_d     = fp_sqrt(operand_a);
            default:   ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            result_add_sub_q <= 64'd0;
            result_mul_q     <= 64'd0;
            result_div_q     <= 64'd0;
        end else begin
            result_add_sub_q <= result_add_sub_d;
            result_mul_q     <= result_mul_d;
            result_div_q     <= result_div_d;
        end
    end

    assign result_add_sub = result_add_sub_q;
    assign result_mul     = result_mul_q;
    assign result_div     = result_div_q;

endmodule

// File: tb/tb_floating_point_alu.sv
// Bench for floating_point_alu: directed vectors plus random operations checked against
// a model built on the simulator's native double arithmetic with flush-to-zero applied.
module tb_floating_point_alu;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  fpalu_mode = 3'b111;
    logic [63:0] operand_a = 64'd0;
    logic [63:0] operand_b = 64'd0;
    logic [63:0] result_add_sub;
    logic [63:0] result_mul;
    logic [63:0] result_div;

    logic [63:0] exp_as  = 64'd0;
    logic [63:0] exp_mul = 64'd0;
    logic [63:0] exp_div = 64'd0;
    int          n_checks = 0;
    int          n_pass   = 0;

    floating_point_alu dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .fpalu_mode     (fpalu_mode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .result_add_sub (result_add_sub),
        .result_mul     (result_mul),
        .result_div     (result_div)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] flush_in(input logic [63:0] x);
        return (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
    endfunction

    function automatic logic [63:0] ref_op(input logic [2:0] mode, input logic [63:0] a,
                                           input logic [63:0] b);
        real         ra, rb, rr;
        logic [63:0] bits;
        ra = $bitstoreal(flush_in(a));
        rb = $bitstoreal(flush_in(b));
        case (mode)
            3'd0:    rr = ra + rb;
            3'd1:    rr = ra - rb;
            3'd2:    rr = ra * rb;
            3'd3:    rr = ra / rb;
            default: rr = $sqrt(ra);
        endcase
        bits = $realtobits(rr);
        if (bits[62:52] == 11'h7FF && bits[51:0] != 52'd0)
            bits = QNAN;
        else if (bits[62:52] == 11'd0)
            bits = {bits[63], 63'd0};
        return bits;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] x;
        logic [10:0] e;
        int unsigned kind;
        kind = $urandom_range(0, 31);
        x    = {$urandom, $urandom};
        e    = 11'(823 + $urandom_range(0, 400));
        case (kind)
            0:       x = {x[63], 63'd0};
            1:       x = {x[63], 11'h7FF, 52'd0};
            2:       x = {x[63], 11'h7FF, 1'b1, x[50:0]};
            3:       x = {x[63], 11'd0, x[51:0]};
            default: x = {x[63], e, x[51:0]};
        endcase
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/add_sub"}, result_add_sub, exp_as);
        check({tag, "/mul"}, result_mul, exp_mul);
        check({tag, "/div"}, result_div, exp_div);
    endtask

    task automatic apply(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b,
                         input string tag);
        fpalu_mode = mode;
        operand_a  = a;
        operand_b  = b;
        @(posedge Clock);
        #1;
        case (mode)
            3'd0, 3'd1: exp_as  = ref_op(mode, a, b);
            3'd2:       exp_mul = ref_op(mode, a, b);
            3'd3, 3'd4: exp_div = ref_op(mode, a, b);
            default:    ;
        endcase
        check_all(tag);
    endtask

    task automatic do_reset(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b,
                            input string tag);
        Reset      = 1'b1;
        fpalu_mode = mode;
        operand_a  = a;
        operand_b  = b;
        @(posedge Clock);
        #1;
        Reset   = 1'b0;
        exp_as  = 64'd0;
        exp_mul = 64'd0;
        exp_div = 64'd0;
        check_all(tag);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [2:0]  rm;

        do_reset(3'b111, 64'd0, 64'd0, "reset");

        apply(3'b000, 64'h4034800000000000, 64'h4016000000000000, "add");
        check("add_lit", result_add_sub, 64'h403A000000000000);
        apply(3'b001, 64'h4041000000000000, 64'h4000000000000000, "sub");
        check("sub_lit", result_add_sub, 64'h4040000000000000);
        apply(3'b010, 64'hC054200000000000, 64'h4016000000000000, "mul");
        check("mul_lit", result_mul, 64'hC07BAC0000000000);
        check("mul_hold_as", result_add_sub, 64'h4040000000000000);
        apply(3'b011, 64'h4059000000000000, 64'hC020000000000000, "div");
        check("div_lit", result_div, 64'hC029000000000000);
        apply(3'b011, 64'h4054200000000000, 64'h0000000000000000, "div_by_zero");
        check("div0_lit", result_div, 64'h7FF0000000000000);
        apply(3'b100, 64'h4054400000000000, 64'h0123456789ABCDEF, "sqrt");
        check("sqrt_lit", result_div, 64'h4022000000000000);
        apply(3'b100, 64'hC000000000000000, 64'd0, "sqrt_neg");
        check("sqrt_neg_lit", result_div, QNAN);
        apply(3'b001, 64'h4041000000000000, 64'h400199999999999A, "sub_rne");
        check("sub_rne_lit", result_add_sub, 64'h403FCCCCCCCCCCCD);
        apply(3'b111, 64'h4041000000000000, 64'h4000000000000000, "noop111");
        apply(3'b101, 64'h3FF0000000000000, 64'h3FF0000000000000, "noop101");
        apply(3'b010, 64'h0000000000000000, 64'h7FF0000000000000, "mul_0_inf");
        check("mul_0_inf_lit", result_mul, QNAN);

        apply(3'b010, 64'h7FE0000000000000, 64'h4000000000000000, "mul_ovf");
        check("mul_ovf_lit", result_mul, 64'h7FF0000000000000);
        apply(3'b010, 64'h0010000000000000, 64'h3FE0000000000000, "mul_unf");
        check("mul_unf_lit", result_mul, 64'h0000000000000000);
        apply(3'b000, 64'h000FFFFFFFFFFFFF, 64'h3FF0000000000000, "add_subnormal");
        check("add_subn_lit", result_add_sub, 64'h3FF0000000000000);
        apply(3'b001, 64'h3FF0000000000000, 64'h3C30000000000000, "sub_far");
        check("sub_far_lit", result_add_sub, 64'h3FF0000000000000);
        apply(3'b001, 64'h4041000000000000, 64'h4041000000000000, "sub_exact_zero");
        check("sub_zero_lit", result_add_sub, 64'h0000000000000000);
        apply(3'b000, 64'h8000000000000000, 64'h8000000000000000, "add_negzeros");
        check("add_negzero_lit", result_add_sub, 64'h8000000000000000);
        apply(3'b000, 64'h7FF0000000000000, 64'hFFF0000000000000, "inf_minus_inf");
        apply(3'b000, 64'h7FF0000000000000, 64'hC000000000000000, "inf_plus_fin");
        apply(3'b100, 64'h8000000000000000, 64'd0, "sqrt_negzero");
        apply(3'b100, 64'h7FF0000000000000, 64'd0, "sqrt_inf");
        apply(3'b011, 64'h0000000000000000, 64'h8000000000000000, "div_0_0");
        apply(3'b011, 64'hFFF0000000000000, 64'h7FF0000000000000, "div_inf_inf");
        apply(3'b011, 64'hBFF0000000000000, 64'h7FF0000000000000, "div_x_inf");
        apply(3'b011, 64'h7FF0000000000000, 64'hC000000000000000, "div_inf_x");
        apply(3'b011, 64'h0000000000000000, 64'hC000000000000000, "div_0_x");
        apply(3'b010, 64'h7FF4000000000000, 64'h3FF0000000000000, "mul_nan");
        apply(3'b100, 64'h3FF8000000000000, 64'd0, "sqrt_1p5");
        apply(3'b100, 64'h4000000000000000, 64'd0, "sqrt_2");

        do_reset(3'b010, 64'h4000000000000000, 64'h4000000000000000, "reset_with_op");

        for (int i = 0; i < 600; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            rm = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                rb = {rb[63], ra[62:52], rb[51:0]};
            apply(rm, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
